// File: rtl/conv_layer_scheduler_if.sv
// rtl/conv_layer_scheduler_if.sv - upstream pixel handshake and paced layer pixel strobe
interface conv_layer_scheduler_if #(
  parameter int BitSize = 8
);
  logic               s_valid;
  logic [BitSize-1:0] s_data;
  logic               s_ready;
  logic               layer_in_valid;
  logic [BitSize-1:0] layer_in_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, layer_in_valid, layer_in_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, layer_in_valid, layer_in_data
  );
endinterface

// File: rtl/conv_layer_scheduler.sv
// rtl/conv_layer_scheduler.sv - paces one frame of pixels into a conv/pool layer, then drains and clears it
module conv_layer_scheduler #(
  parameter int BitSize        = 8,
  parameter int ImageWidth     = 16,
  parameter int CyclesPerPixel = 8,
  parameter int DrainTimeout   = 1024,
  localparam int Total         = ImageWidth * ImageWidth,
  localparam int IdxW          = $clog2(Total + 1)
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 start,
  conv_layer_scheduler_if.slave bus,
  input  logic                 pooling_done,
  output logic                 layer_rst,
  output logic                 busy,
  output logic [IdxW-1:0]      pixel_idx,
  output logic                 frame_done,
  output logic                 timeout_err
);

  localparam int PaceW  = (CyclesPerPixel > 1) ? $clog2(CyclesPerPixel) : 1;
  localparam int DrainW = $clog2(DrainTimeout);

  localparam logic [PaceW-1:0]  PaceLoad  = PaceW'(CyclesPerPixel - 1);
  localparam logic [IdxW-1:0]   TotalIdx  = IdxW'(Total);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainTimeout - 1);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t            state, state_nx;
  logic [PaceW-1:0]  pace, pace_nx;
  logic [IdxW-1:0]   idx_nx;
  logic [DrainW-1:0] drain_cnt, drain_nx;
  logic              ready_c;
  logic              accept;
  logic              timeout_set;

  always_comb begin
    state_nx    = state;
    pace_nx     = pace;
    idx_nx      = pixel_idx;
    drain_nx    = drain_cnt;
    ready_c     = 1'b0;
    accept      = 1'b0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        // busy is still high in the frame_done cycle, so a start there is dropped
        if (start && !busy) begin
          state_nx = FEED;
          idx_nx   = '0;
          pace_nx  = '0;
        end
      end
      FEED: begin
        ready_c = (pace == '0) && (pixel_idx < TotalIdx);
        accept  = ready_c && bus.s_valid;
        if (pace != '0) begin
          pace_nx = pace - 1'b1;
        end
        if (accept) begin
          pace_nx = PaceLoad;
          idx_nx  = pixel_idx + 1'b1;
          if (pixel_idx == TotalIdx - 1'b1) begin
            state_nx = DRAIN;
            drain_nx = '0;
          end
        end
      end
      DRAIN: begin
        drain_nx = drain_cnt + 1'b1;
        if (pooling_done) begin
          state_nx = DONE;
        end else if (drain_cnt == DrainLast) begin
          timeout_set = 1'b1;
          state_nx    = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.s_ready = ready_c;

  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      state              <= IDLE;
      pace               <= '0;
      pixel_idx          <= '0;
      drain_cnt          <= '0;
      bus.layer_in_valid <= 1'b0;
      bus.layer_in_data  <= '0;
      layer_rst          <= 1'b1;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      state              <= state_nx;
      pace               <= pace_nx;
      pixel_idx          <= idx_nx;
      drain_cnt          <= drain_nx;
      bus.layer_in_valid <= accept;
      if (accept) begin
        bus.layer_in_data <= bus.s_data;
      end
      layer_rst  <= (state == DONE);
      frame_done <= (state == DONE);
      busy       <= (state_nx != IDLE) || (state == DONE);
      if (timeout_set) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb/tb_conv_layer_scheduler.sv - randomized bench for conv_layer_scheduler against a frame-level model
module tb_conv_layer_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, start, sv, pd;
  logic [7:0] sd [2];
  wire  [1:0] sr, liv, lrst, busy, fd, te;
  wire  [7:0] lid [2];
  wire  [4:0] pidx [2];

  conv_layer_scheduler_if #(.BitSize(8)) if_a ();
  conv_layer_scheduler_if #(.BitSize(8)) if_b ();

  assign if_a.s_valid = sv[0];
  assign if_a.s_data  = sd[0];
  assign sr[0]        = if_a.s_ready;
  assign liv[0]       = if_a.layer_in_valid;
  assign lid[0]       = if_a.layer_in_data;
  assign if_b.s_valid = sv[1];
  assign if_b.s_data  = sd[1];
  assign sr[1]        = if_b.s_ready;
  assign liv[1]       = if_b.layer_in_valid;
  assign lid[1]       = if_b.layer_in_data;

  // dut_a: 3 cycles per pixel, short drain timeout; dut_b: 1 cycle per pixel, long timeout
  conv_layer_scheduler #(.BitSize(8), .ImageWidth(4), .CyclesPerPixel(3), .DrainTimeout(8)) dut_a (
    .clk(clk), .res_n(rst[0]), .start(start[0]), .bus(if_a), .pooling_done(pd[0]),
    .layer_rst(lrst[0]), .busy(busy[0]), .pixel_idx(pidx[0]), .frame_done(fd[0]), .timeout_err(te[0])
  );
  conv_layer_scheduler #(.BitSize(8), .ImageWidth(4), .CyclesPerPixel(1), .DrainTimeout(32)) dut_b (
    .clk(clk), .res_n(rst[1]), .start(start[1]), .bus(if_b), .pooling_done(pd[1]),
    .layer_rst(lrst[1]), .busy(busy[1]), .pixel_idx(pidx[1]), .frame_done(fd[1]), .timeout_err(te[1])
  );

  int checks = 0;
  int failures = 0;

  int r_hang, r_ready_err, r_valid_err, r_idx_err, r_busy_err, r_fd_err, r_te_err, r_data_err;
  int r_min_gap, r_max_gap, r_pulses;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit [1:0] te_model;

  // Drives one full frame and tallies every cycle-level deviation from the model.
  task automatic run_frame(input int d, input int pct, input int pool_at, input bit noise);
    int cpp, dt, acc, last_acc, t, prev_pulse, fd_j;
    bit acc_prev, exp_ready, to;
    logic [7:0] acc_data;
    cpp = (d == 0) ? 3 : 1;
    dt  = (d == 0) ? 8 : 32;
    acc = 0; last_acc = -1000; t = 0; prev_pulse = -1; acc_prev = 1'b0; acc_data = '0;
    r_hang = 0; r_ready_err = 0; r_valid_err = 0; r_idx_err = 0; r_busy_err = 0;
    r_fd_err = 0; r_te_err = 0; r_data_err = 0; r_pulses = 0;
    r_min_gap = 1 << 30; r_max_gap = 0;
    exp_q.delete(); got_q.delete();
    @(negedge clk);
    start[d] = 1'b1; sv[d] = 1'b0; pd[d] = 1'b0;
    while (acc < 16 && t < 500) begin
      @(negedge clk);
      start[d] = noise && ($urandom_range(3) == 0);
      pd[d]    = noise && ($urandom_range(1) == 0);
      exp_ready = (t - last_acc >= cpp);
      if (sr[d] !== exp_ready) r_ready_err++;
      if (liv[d] !== acc_prev || (acc_prev && lid[d] !== acc_data)) r_valid_err++;
      if (liv[d] === 1'b1) begin
        got_q.push_back(lid[d]);
        r_pulses++;
        if (prev_pulse >= 0) begin
          if (t - prev_pulse < r_min_gap) r_min_gap = t - prev_pulse;
          if (t - prev_pulse > r_max_gap) r_max_gap = t - prev_pulse;
        end
        prev_pulse = t;
      end
      if (pidx[d] !== 5'(acc)) r_idx_err++;
      if (busy[d] !== 1'b1) r_busy_err++;
      if (fd[d] !== 1'b0 || lrst[d] !== 1'b0) r_fd_err++;
      if (te[d] !== te_model[d]) r_te_err++;
      sv[d] = ($urandom_range(99) < pct);
      sd[d] = (pct == 100) ? 8'(acc + 1) : 8'($urandom);
      acc_prev = exp_ready && sv[d];
      if (acc_prev) begin
        exp_q.push_back(sd[d]);
        acc_data = sd[d];
        acc++;
        last_acc = t;
      end
      t++;
    end
    if (acc < 16) r_hang++;
    to   = (pool_at > dt - 1);
    fd_j = (to ? dt - 1 : pool_at) + 2;
    for (int j = 0; j <= fd_j + 1; j++) begin
      @(negedge clk);
      start[d] = noise && (j == fd_j || (j < fd_j && $urandom_range(1) == 0));
      sv[d] = ($urandom_range(1) == 0);
      if (sr[d] !== 1'b0) r_ready_err++;
      if (liv[d] !== ((j == 0) ? acc_prev : 1'b0) || (j == 0 && acc_prev && lid[d] !== acc_data)) r_valid_err++;
      if (liv[d] === 1'b1) begin
        got_q.push_back(lid[d]);
        r_pulses++;
        if (prev_pulse >= 0) begin
          if (t - prev_pulse < r_min_gap) r_min_gap = t - prev_pulse;
          if (t - prev_pulse > r_max_gap) r_max_gap = t - prev_pulse;
        end
        prev_pulse = t;
      end
      if (pidx[d] !== 5'(acc)) r_idx_err++;
      if (busy[d] !== (j <= fd_j)) r_busy_err++;
      if (fd[d] !== (j == fd_j) || lrst[d] !== (j == fd_j)) r_fd_err++;
      if (te[d] !== (te_model[d] | (to && j >= dt))) r_te_err++;
      pd[d] = (j >= pool_at);
      t++;
    end
    start[d] = 1'b0; sv[d] = 1'b0; pd[d] = 1'b0;
    if (to) te_model[d] = 1'b1;
    if (got_q.size() != exp_q.size()) r_data_err++;
    else foreach (got_q[i]) if (got_q[i] !== exp_q[i]) r_data_err++;
  endtask

  task automatic pulse_reset(input int d);
    @(negedge clk);
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    te_model[d] = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (sr[d] !== 1'b0) begin failures++; $display("FAIL reset_s_ready dut%0d got=%b want=0", d, sr[d]); end
      checks++; if (liv[d] !== 1'b0 || lid[d] !== 8'h00) begin failures++; $display("FAIL reset_layer_in dut%0d got=%b/%h want=0/00", d, liv[d], lid[d]); end
      checks++; if (lrst[d] !== 1'b1) begin failures++; $display("FAIL reset_layer_rst dut%0d got=%b want=1", d, lrst[d]); end
      checks++; if (busy[d] !== 1'b0 || fd[d] !== 1'b0 || te[d] !== 1'b0) begin failures++; $display("FAIL reset_flags dut%0d got=%b%b%b want=000", d, busy[d], fd[d], te[d]); end
      checks++; if (pidx[d] !== 5'd0) begin failures++; $display("FAIL reset_pixel_idx dut%0d got=%0d want=0", d, pidx[d]); end
    end
    rst = 2'b00;
    #1;
    checks++; if (lrst !== 2'b11) begin failures++; $display("FAIL reset_release_hold got=%b want=11", lrst); end
    @(negedge clk);
    checks++; if (lrst !== 2'b00) begin failures++; $display("FAIL reset_release_drop got=%b want=00", lrst); end
    checks++; if (busy !== 2'b00 || sr !== 2'b00) begin failures++; $display("FAIL reset_idle got=%b/%b want=00/00", busy, sr); end
  endtask

  task automatic test_pacing;
    int bad;
    run_frame(0, 100, 3, 1'b0);
    bad = 0;
    foreach (got_q[i]) if (got_q[i] !== 8'(i + 1)) bad++;
    checks++; if (r_hang != 0 || r_pulses != 16) begin failures++; $display("FAIL pacing_pulses got=%0d want=16", r_pulses); end
    checks++; if (bad != 0 || got_q.size() != 16) begin failures++; $display("FAIL pacing_data got=%0d_bad want=0", bad); end
    checks++; if (r_min_gap != 3 || r_max_gap != 3) begin failures++; $display("FAIL pacing_gap got=%0d..%0d want=3..3", r_min_gap, r_max_gap); end
    checks++; if (r_ready_err != 0) begin failures++; $display("FAIL pacing_ready got=%0d want=0", r_ready_err); end
    checks++; if (r_valid_err != 0 || r_idx_err != 0) begin failures++; $display("FAIL pacing_valid_idx got=%0d/%0d want=0/0", r_valid_err, r_idx_err); end
    checks++; if (pidx[0] !== 5'd16) begin failures++; $display("FAIL pacing_final_idx got=%0d want=16", pidx[0]); end
  endtask

  task automatic test_stalls;
    for (int k = 0; k < 2; k++) begin
      run_frame(1, 50, 0, 1'b0);
      checks++; if (r_hang != 0 || r_data_err != 0) begin failures++; $display("FAIL stalls_data got=%0d want=0", r_data_err); end
      checks++; if (r_valid_err != 0 || r_pulses != 16) begin failures++; $display("FAIL stalls_pulses got=%0d/%0d want=0/16", r_valid_err, r_pulses); end
      checks++; if (r_ready_err != 0 || r_min_gap < 1) begin failures++; $display("FAIL stalls_ready got=%0d want=0", r_ready_err); end
      checks++; if (r_fd_err != 0 || r_busy_err != 0) begin failures++; $display("FAIL stalls_drain_entry got=%0d/%0d want=0/0", r_fd_err, r_busy_err); end
    end
  endtask

  task automatic test_drain;
    run_frame(1, 100, 10, 1'b0);
    checks++; if (r_fd_err != 0) begin failures++; $display("FAIL drain_done got=%0d want=0", r_fd_err); end
    checks++; if (r_te_err != 0 || te[1] !== 1'b0) begin failures++; $display("FAIL drain_no_timeout got=%b want=0", te[1]); end
    checks++; if (r_busy_err != 0) begin failures++; $display("FAIL drain_busy got=%0d want=0", r_busy_err); end
    run_frame(1, 100, 4, 1'b0);
    checks++; if (r_data_err != 0 || r_hang != 0) begin failures++; $display("FAIL drain_second_data got=%0d want=0", r_data_err); end
    checks++; if (r_fd_err != 0 || r_idx_err != 0) begin failures++; $display("FAIL drain_second_done got=%0d/%0d want=0/0", r_fd_err, r_idx_err); end
  endtask

  task automatic test_timeout;
    run_frame(0, 100, 1000, 1'b0);
    checks++; if (r_te_err != 0) begin failures++; $display("FAIL timeout_timing got=%0d want=0", r_te_err); end
    checks++; if (te[0] !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b want=1", te[0]); end
    checks++; if (r_fd_err != 0 || r_busy_err != 0) begin failures++; $display("FAIL timeout_done got=%0d/%0d want=0/0", r_fd_err, r_busy_err); end
    run_frame(0, 80, 2, 1'b0);
    checks++; if (r_te_err != 0 || te[0] !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b want=1", te[0]); end
    checks++; if (r_data_err != 0 || r_fd_err != 0) begin failures++; $display("FAIL timeout_good_frame got=%0d/%0d want=0/0", r_data_err, r_fd_err); end
    pulse_reset(0);
    run_frame(0, 100, 7, 1'b0);
    checks++; if (r_te_err != 0 || te[0] !== 1'b0) begin failures++; $display("FAIL timeout_tie got=%b want=0", te[0]); end
    checks++; if (r_fd_err != 0) begin failures++; $display("FAIL timeout_tie_done got=%0d want=0", r_fd_err); end
  endtask

  task automatic test_ignored_start;
    run_frame(0, 70, 5, 1'b1);
    checks++; if (r_busy_err != 0) begin failures++; $display("FAIL ignstart_busy got=%0d want=0", r_busy_err); end
    checks++; if (r_idx_err != 0 || r_hang != 0) begin failures++; $display("FAIL ignstart_idx got=%0d want=0", r_idx_err); end
    checks++; if (r_fd_err != 0 || r_te_err != 0) begin failures++; $display("FAIL ignstart_done got=%0d/%0d want=0/0", r_fd_err, r_te_err); end
    checks++; if (r_data_err != 0 || r_valid_err != 0 || r_ready_err != 0) begin failures++; $display("FAIL ignstart_data got=%0d/%0d/%0d want=0/0/0", r_data_err, r_valid_err, r_ready_err); end
    run_frame(1, 60, 3, 1'b1);
    checks++; if (r_busy_err != 0 || r_fd_err != 0 || r_data_err != 0) begin failures++; $display("FAIL ignstart_b got=%0d/%0d/%0d want=0/0/0", r_busy_err, r_fd_err, r_data_err); end
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    sv[0] = 1'b1;
    sd[0] = 8'h5a;
    n = 0;
    while (pidx[0] !== 5'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (pidx[0] !== 5'd7) begin failures++; $display("FAIL midreset_reach got=%0d want=7", pidx[0]); end
    #2;
    rst[0] = 1'b1;
    #1;
    checks++; if (sr[0] !== 1'b0 || liv[0] !== 1'b0 || lid[0] !== 8'h00) begin failures++; $display("FAIL midreset_stream got=%b%b/%h want=00/00", sr[0], liv[0], lid[0]); end
    checks++; if (lrst[0] !== 1'b1 || busy[0] !== 1'b0 || fd[0] !== 1'b0) begin failures++; $display("FAIL midreset_ctrl got=%b%b%b want=100", lrst[0], busy[0], fd[0]); end
    checks++; if (pidx[0] !== 5'd0 || te[0] !== 1'b0) begin failures++; $display("FAIL midreset_idx got=%0d/%b want=0/0", pidx[0], te[0]); end
    sv[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    te_model[0] = 1'b0;
    #1;
    checks++; if (lrst[0] !== 1'b1) begin failures++; $display("FAIL midreset_hold got=%b want=1", lrst[0]); end
    @(negedge clk);
    checks++; if (lrst[0] !== 1'b0 || busy[0] !== 1'b0 || sr[0] !== 1'b0 || pidx[0] !== 5'd0) begin failures++; $display("FAIL midreset_release got=%b%b%b/%0d want=000/0", lrst[0], busy[0], sr[0], pidx[0]); end
    run_frame(0, 100, 1, 1'b0);
    checks++; if (r_data_err != 0 || r_fd_err != 0 || r_idx_err != 0) begin failures++; $display("FAIL midreset_next_frame got=%0d/%0d/%0d want=0/0/0", r_data_err, r_fd_err, r_idx_err); end
  endtask

  initial begin
    rst = 2'b11; start = 2'b00; sv = 2'b00; pd = 2'b00;
    sd[0] = 8'h00; sd[1] = 8'h00;
    te_model = 2'b00;
    test_reset();
    test_pacing();
    test_stalls();
    test_drain();
    test_timeout();
    test_ignored_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
